// File: rtl/pkt_key_extract.sv
// Receive-path header parser: extracts the 96-bit flow key and 4-bit flag from
// untagged IPv4 TCP/UDP frames (IHL=5) and keeps frame/key/runt statistics.
module pkt_key_extract #(
    parameter int KEY_SIZE  = 96,
    parameter int CNT_WIDTH = 32,
    parameter bit DROP_FRAG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          rx_tdata,
    input  logic                 rx_tvalid,
    input  logic                 rx_tlast,
    output logic [KEY_SIZE-1:0]  out_key,
    output logic [3:0]           out_flag,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] key_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, HDR, WAIT} state_t;

    localparam logic [2:0] LAST_HDR_BEAT = 3'd5;

    state_t      state, state_next;
    logic [2:0]  beat_idx, beat_idx_next;

    logic [15:0] ethertype, frag_word, src_port, dst_port;
    logic [7:0]  ver_ihl, proto, tcp_bits;
    logic [31:0] src_ip, dst_ip;

    logic at_beat5, runt_end, frag_ok, qualified, emit, is_tcp, is_udp;
    logic [3:0] flag_next;

    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        beat_idx_next = beat_idx;
        if (rx_tvalid) begin
            if (beat_idx != LAST_HDR_BEAT)
                beat_idx_next = beat_idx + 3'd1;
            unique case (state)
                IDLE:    state_next = rx_tlast ? IDLE : HDR;
                HDR: begin
                    if (rx_tlast)
                        state_next = IDLE;
                    else if (beat_idx == LAST_HDR_BEAT)
                        state_next = WAIT;
                end
                WAIT:    if (rx_tlast) state_next = IDLE;
                default: state_next = IDLE;
            endcase
            if (rx_tlast)
                beat_idx_next = '0;
        end
    end

    // TCP flags arrive on beat5 itself, so they are taken straight off the bus.
    always_comb begin
        tcp_bits  = rx_tdata[63:56];
        at_beat5  = rx_tvalid && (state == HDR) && (beat_idx == LAST_HDR_BEAT);
        runt_end  = rx_tvalid && rx_tlast && (beat_idx < LAST_HDR_BEAT);
        frag_ok   = !DROP_FRAG || (!frag_word[13] && (frag_word[12:0] == 13'd0));
        is_tcp    = (proto == 8'h06);
        is_udp    = (proto == 8'h11);
        qualified = (ethertype == 16'h0800) && (ver_ihl == 8'h45) &&
                    (is_tcp || is_udp) && frag_ok;
        emit      = at_beat5 && qualified;
        flag_next = is_tcp ? {tcp_bits[0] | tcp_bits[2], tcp_bits[1], 1'b0, 1'b1}
                           : 4'b0010;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_idx  <= '0;
            out_valid <= 1'b0;
            out_key   <= '0;
            out_flag  <= '0;
            frame_cnt <= '0;
            key_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_next;
            beat_idx  <= beat_idx_next;
            out_valid <= emit;
            if (emit) begin
                out_key  <= {src_ip, dst_ip, src_port, dst_port};
                out_flag <= flag_next;
            end
            if (rx_tvalid && rx_tlast)
                frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            if (runt_end)
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            key_cnt <= key_cnt + CNT_WIDTH'(out_valid);
        end
    end

    // NOTE: header field registers are pure datapath, always rewritten before
    // use within a frame, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rx_tvalid && state == HDR) begin
            unique case (beat_idx)
                3'd1: begin
                    ethertype <= {rx_tdata[39:32], rx_tdata[47:40]};
                    ver_ihl   <= rx_tdata[55:48];
                end
                3'd2: begin
                    frag_word <= {rx_tdata[39:32], rx_tdata[47:40]};
                    proto     <= rx_tdata[63:56];
                end
                3'd3: begin
                    src_ip        <= {rx_tdata[23:16], rx_tdata[31:24],
                                      rx_tdata[39:32], rx_tdata[47:40]};
                    dst_ip[31:16] <= {rx_tdata[55:48], rx_tdata[63:56]};
                end
                3'd4: begin
                    dst_ip[15:0] <= {rx_tdata[7:0], rx_tdata[15:8]};
                    src_port     <= {rx_tdata[23:16], rx_tdata[31:24]};
                    dst_port     <= {rx_tdata[39:32], rx_tdata[47:40]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_key_extract.sv
// Scoreboard bench for pkt_key_extract: directed frames push expected keys,
// a negedge monitor pops and compares every out_valid pulse.
module tb_pkt_key_extract;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rx_tdata;
    logic        rx_tvalid;
    logic        rx_tlast;
    logic [95:0] out_key;
    logic [3:0]  out_flag;
    logic        out_valid;
    logic [31:0] frame_cnt, key_cnt, drop_cnt;

    pkt_key_extract dut (
        .clk       (clk),
        .rst       (rst),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .rx_tlast  (rx_tlast),
        .out_key   (out_key),
        .out_flag  (out_flag),
        .out_valid (out_valid),
        .frame_cnt (frame_cnt),
        .key_cnt   (key_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] key;
        logic [3:0]  flag;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] frame[0:63];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest expectation, 1 clk after beat5.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 96'd1, 96'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_key", out_key, e.key);
                check("out_flag", {92'd0, out_flag}, {92'd0, e.flag});
                check("latency", 96'(cyc), 96'(e.cyc));
            end
        end
    end

    task automatic build(input logic [15:0] etype, input logic [7:0] vihl, input logic [7:0] prot,
                         input logic [15:0] frag, input logic [31:0] sip, input logic [31:0] dip,
                         input logic [15:0] sport, input logic [15:0] dport, input logic [7:0] b47);
        for (int i = 0; i < 64; i++) frame[i] = 8'(i);
        {frame[12], frame[13]} = etype;
        frame[14] = vihl;
        {frame[20], frame[21]} = frag;
        frame[23] = prot;
        {frame[26], frame[27], frame[28], frame[29]} = sip;
        {frame[30], frame[31], frame[32], frame[33]} = dip;
        {frame[34], frame[35]} = sport;
        {frame[36], frame[37]} = dport;
        frame[47] = b47;
    endtask

    task automatic send_frame(input int nbeats, input int gap, input bit expect_key,
                              input logic [95:0] k, input logic [3:0] f, input bit rst_at5);
        for (int b = 0; b < nbeats; b++) begin
            if (b != 0) begin
                for (int g = 0; g < gap; g++) begin
                    rx_tvalid = 1'b0;
                    rx_tlast  = 1'b0;
                    @(posedge clk); #1;
                end
            end
            rx_tvalid = 1'b1;
            rx_tlast  = (b == nbeats - 1);
            for (int l = 0; l < 8; l++) rx_tdata[8*l +: 8] = frame[8*b + l];
            if (b == 5 && expect_key) exp_q.push_back('{key: k, flag: f, cyc: cyc + 1});
            if (b == 5 && rst_at5) rst = 1'b1;
            @(posedge clk); #1;
            if (b == 5 && rst_at5) begin
                rst = 1'b0;
                break;
            end
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input int f, input int k, input int d);
        check({name, "_frame_cnt"}, 96'(frame_cnt), 96'(f));
        check({name, "_key_cnt"}, 96'(key_cnt), 96'(k));
        check({name, "_drop_cnt"}, 96'(drop_cnt), 96'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", {95'd0, out_valid}, 96'd0);
        check("reset_out_key", out_key, 96'd0);
        check("reset_out_flag", {92'd0, out_flag}, 96'd0);
        check_cnt("reset", 0, 0, 0);

        // TCP SYN 10.0.0.1:1234 -> 10.0.0.2:80
        build(16'h0800, 8'h45, 8'h06, 16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02);
        send_frame(8, 0, 1'b1, 96'h0A000001_0A000002_04D2_0050, 4'b0101, 1'b0);
        idle(4); check_cnt("syn", 1, 1, 0);

        // UDP with 3-clk gaps; byte47 bits must not leak into the flag
        build(16'h0800, 8'h45, 8'h11, 16'h0000, 32'hC0A80101, 32'hC0A80109, 16'd53, 16'd5000, 8'hFF);
        send_frame(8, 3, 1'b1, 96'hC0A80101_C0A80109_0035_1388, 4'b0010, 1'b0);
        idle(4); check_cnt("udp", 2, 2, 0);

        // ARP, VLAN, ICMP, IHL=6: none keyed, none dropped
        build(16'h0806, 8'h45, 8'h06, 16'h0000, 32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'h02);
        send_frame(8, 0, 1'b0, '0, '0, 1'b0);
        build(16'h8100, 8'h45, 8'h06, 16'h0000, 32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'h02);
        send_frame(8, 0, 1'b0, '0, '0, 1'b0);
        build(16'h0800, 8'h45, 8'h01, 16'h0000, 32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'h02);
        send_frame(8, 0, 1'b0, '0, '0, 1'b0);
        idle(4); check_cnt("nonip", 5, 2, 0);
        build(16'h0800, 8'h46, 8'h06, 16'h0000, 32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'h02);
        send_frame(8, 0, 1'b0, '0, '0, 1'b0);
        idle(4); check_cnt("ihl6", 6, 2, 0);

        // Runts of 3, 1 and 5 beats carrying otherwise-qualifying headers
        build(16'h0800, 8'h45, 8'h06, 16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02);
        send_frame(3, 0, 1'b0, '0, '0, 1'b0);
        send_frame(1, 0, 1'b0, '0, '0, 1'b0);
        idle(4); check_cnt("runt", 8, 2, 2);
        send_frame(5, 0, 1'b0, '0, '0, 1'b0);
        idle(4); check_cnt("runt5", 9, 2, 3);

        // 6-beat frame (tlast on beat5, FIN) then an 8-beat ACK with no gap
        build(16'h0800, 8'h45, 8'h06, 16'h0000, 32'hAC100001, 32'hAC100002, 16'h1111, 16'h2222, 8'h11);
        send_frame(6, 0, 1'b1, 96'hAC100001_AC100002_1111_2222, 4'b1001, 1'b0);
        build(16'h0800, 8'h45, 8'h06, 16'h0000, 32'h0A0B0C0D, 32'h01020304, 16'h0400, 16'h01BB, 8'h10);
        send_frame(8, 0, 1'b1, 96'h0A0B0C0D_01020304_0400_01BB, 4'b0001, 1'b0);
        idle(4); check_cnt("short6", 11, 4, 3);

        // 100 back-to-back RST frames
        for (int i = 0; i < 100; i++) begin
            build(16'h0800, 8'h45, 8'h06, 16'h0000, 32'h0A010101, 32'h0A010102,
                  16'h1000 + 16'(i), 16'd2000, 8'h04);
            send_frame(8, 0, 1'b1, {32'h0A010101, 32'h0A010102, 16'h1000 + 16'(i), 16'd2000},
                       4'b1001, 1'b0);
        end
        idle(4); check_cnt("rst100", 111, 104, 3);

        // Reset asserted on beat5 of a qualifying frame
        build(16'h0800, 8'h45, 8'h06, 16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02);
        send_frame(8, 0, 1'b0, '0, '0, 1'b1);
        check("midrst_out_valid", {95'd0, out_valid}, 96'd0);
        check("midrst_out_key", out_key, 96'd0);
        check_cnt("midrst", 0, 0, 0);
        idle(2);
        send_frame(8, 0, 1'b1, 96'h0A000001_0A000002_04D2_0050, 4'b0101, 1'b0);
        idle(4); check_cnt("after_rst", 1, 1, 0);

        // Fragments: offset=1 and MF=1 dropped; DF alone is keyed
        build(16'h0800, 8'h45, 8'h11, 16'h0001, 32'h0A000003, 32'h0A000004, 16'd7, 16'd9, 8'h00);
        send_frame(8, 0, 1'b0, '0, '0, 1'b0);
        build(16'h0800, 8'h45, 8'h11, 16'h2000, 32'h0A000003, 32'h0A000004, 16'd7, 16'd9, 8'h00);
        send_frame(8, 0, 1'b0, '0, '0, 1'b0);
        idle(4); check_cnt("frag", 3, 1, 0);
        build(16'h0800, 8'h45, 8'h11, 16'h4000, 32'h0A000003, 32'h0A000004, 16'd7, 16'd9, 8'h00);
        send_frame(8, 0, 1'b1, 96'h0A000003_0A000004_0007_0009, 4'b0010, 1'b0);
        idle(5); check_cnt("df", 4, 2, 0);

        check("pending_expectations", 96'(exp_q.size()), 96'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
